// File: rtl/fixed_mul.sv
// ---------------------------------------------------------------------------
// fixed_mul
//
// Unsigned 16.16 x 16.16 fixed-point multiplier built as a radix-2 shift-add
// engine. Each RUN cycle consumes one multiplier bit. The full 32.32 product,
// its 16.16 truncation and an overflow flag are registered on the final
// step, and they hold until the next completion.
//
// Configuration macro:
//   FIXED_MUL_EARLY_EXIT_EN
//     Defined:   RUN also ends as soon as the remaining multiplier bits are
//                all zero. Latency becomes max(1, msb(multiplier)+1) cycles.
//     Undefined: latency is a fixed 32 cycles for every operand pair.
//
// Ports:
//   clk          in   1   single clock, rising edge
//   rstn         in   1   asynchronous active-low reset
//   start        in   1   request, sampled only while idle
//   multiplicand in  32   unsigned 16.16 operand A
//   multiplier   in  32   unsigned 16.16 operand B
//   product      out 64   full raw product A*B (32.32)
//   scaled       out 32   product[47:16], the 16.16 result
//   ovf          out  1   product[63:48] is nonzero
//   busy         out  1   high while a multiplication is running
//   done         out  1   one-cycle completion pulse
// ---------------------------------------------------------------------------
module fixed_mul (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [31:0] multiplicand,
    input  logic [31:0] multiplier,
    output logic [63:0] product,
    output logic [31:0] scaled,
    output logic        ovf,
    output logic        busy,
    output logic        done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      r_state;
    logic [63:0] r_acc;
    logic [63:0] r_mcand;
    logic [31:0] r_mplier;
    logic [4:0]  r_count;
    logic [63:0] r_product;
    logic [31:0] r_scaled;
    logic        r_ovf;
    logic        r_busy;
    logic        r_done;

    logic [63:0] w_addend;
    logic [63:0] w_accNext;
    logic [31:0] w_mplierNext;
    logic        w_lastStep;

    // The partial product for this step is the shifted multiplicand when the
    // current multiplier LSB is set, otherwise zero.
    always_comb begin
        w_addend     = r_mplier[0] ? r_mcand : 64'd0;
        w_accNext    = r_acc + w_addend;
        w_mplierNext = r_mplier >> 1;
    end

    // The step counter bounds the run at 32 steps. With early exit enabled,
    // a run also ends once no set multiplier bits remain, because every
    // further step would add zero.
`ifdef FIXED_MUL_EARLY_EXIT_EN
    always_comb begin
        w_lastStep = (r_count == 5'd31) || (w_mplierNext == 32'd0);
    end
`else
    always_comb begin
        w_lastStep = (r_count == 5'd31);
    end
`endif

    // Single sequencing process. IDLE latches the operands on start and
    // clears the working registers. RUN performs one shift-add step per
    // edge and publishes the result on the exit edge. The done pulse
    // defaults low every cycle, so it lasts exactly one cycle. Start
    // is only examined in IDLE, so requests made while running are dropped
    // rather than queued. The result registers change only on the exit edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= IDLE;
            r_acc     <= 64'd0;
            r_mcand   <= 64'd0;
            r_mplier  <= 32'd0;
            r_count   <= 5'd0;
            r_product <= 64'd0;
            r_scaled  <= 32'd0;
            r_ovf     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_acc    <= 64'd0;
                        r_mcand  <= {32'd0, multiplicand};
                        r_mplier <= multiplier;
                        r_count  <= 5'd0;
                        r_busy   <= 1'b1;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    r_acc    <= w_accNext;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= w_mplierNext;
                    r_count  <= r_count + 5'd1;
                    if (w_lastStep) begin
                        r_product <= w_accNext;
                        r_scaled  <= w_accNext[47:16];
                        r_ovf     <= |w_accNext[63:48];
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign product = r_product;
    assign scaled  = r_scaled;
    assign ovf     = r_ovf;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_fixed_mul.sv
// ---------------------------------------------------------------------------
// tb_fixed_mul
//
// Scoreboard bench for fixed_mul. The stimulus side pushes the hand-computed
// result of every accepted request together with its acceptance cycle. A
// separate monitor pops one entry on each done pulse and compares product,
// scaled, ovf and the observed latency. Latency expectations follow the
// FIXED_MUL_EARLY_EXIT_EN build setting.
// ---------------------------------------------------------------------------
module tb_fixed_mul;

    logic        clk;
    logic        rstn;
    logic        start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic [63:0] product;
    logic [31:0] scaled;
    logic        ovf;
    logic        busy;
    logic        done;

`ifdef FIXED_MUL_EARLY_EXIT_EN
    localparam bit EarlyExit = 1'b1;
`else
    localparam bit EarlyExit = 1'b0;
`endif

    typedef struct {
        logic [63:0] prod;
        logic [31:0] scal;
        logic        ovfl;
        int          lat;
        int          e0;
        string       tag;
    } expect_t;

    expect_t scoreboard[$];

    int cycleCount    = 0;
    int compareCount  = 0;
    int mismatchCount = 0;
    logic [63:0] lastProduct;

    fixed_mul dut (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product      (product),
        .scaled       (scaled),
        .ovf          (ovf),
        .busy         (busy),
        .done         (done)
    );

    // Free-running clock and an edge counter used to measure latency.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Compare one value and report a mismatch on a single line.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        compareCount++;
        if (act !== req) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Issue one request, record its expectation once the accepting edge has
    // passed, and optionally keep start asserted afterwards.
    task automatic applyStimulus(input string tag, input logic [31:0] a, input logic [31:0] b,
                                 input logic [63:0] expProd, input logic [31:0] expScaled,
                                 input logic expOvf, input int earlyLat, input bit holdStart);
        expect_t e;
        @(negedge clk);
        start        = 1'b1;
        multiplicand = a;
        multiplier   = b;
        @(posedge clk);
        #1;
        e.prod = expProd;
        e.scal = expScaled;
        e.ovfl = expOvf;
        e.lat  = EarlyExit ? earlyLat : 32;
        e.e0   = cycleCount;
        e.tag  = tag;
        scoreboard.push_back(e);
        lastProduct = expProd;
        if (!holdStart) begin
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    // Wait a bounded number of cycles for a done pulse.
    task automatic waitForDone(input string tag, input int maxCycles);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < maxCycles; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            compareCount++;
            mismatchCount++;
            $display("[TB] FAIL %s timeout: no done within %0d cycles", tag, maxCycles);
        end
    endtask

    // Monitor: every done pulse consumes exactly one scoreboard entry.
    always @(negedge clk) begin
        if (rstn === 1'b1 && done === 1'b1) begin
            if (scoreboard.size() == 0) begin
                compareCount++;
                mismatchCount++;
                $display("[TB] FAIL unexpectedDone: got done=1 at cycle %0d, required no pulse", cycleCount);
            end else begin
                expect_t e;
                e = scoreboard.pop_front();
                checkOutput({e.tag, " product"}, product, e.prod);
                checkOutput({e.tag, " scaled"}, {32'd0, scaled}, {32'd0, e.scal});
                checkOutput({e.tag, " ovf"}, {63'd0, ovf}, {63'd0, e.ovfl});
                checkOutput({e.tag, " latency"}, 64'(cycleCount - e.e0), 64'(e.lat));
            end
        end
    end

    initial begin
        rstn         = 1'b0;
        start        = 1'b0;
        multiplicand = 32'd0;
        multiplier   = 32'd0;
        lastProduct  = 64'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset product", product, 64'd0);
        checkOutput("reset scaled", {32'd0, scaled}, 64'd0);
        checkOutput("reset busy", {63'd0, busy}, 64'd0);
        checkOutput("reset done", {63'd0, done}, 64'd0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("idle busy", {63'd0, busy}, 64'd0);

        $display("[TB] directed vectors");
        applyStimulus("oneXone", 32'h0001_0000, 32'h0001_0000,
                      64'h0000_0001_0000_0000, 32'h0001_0000, 1'b0, 17, 1'b0);
        waitForDone("oneXone", 40);
        applyStimulus("maxXmax", 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                      64'hFFFF_FFFE_0000_0001, 32'hFFFE_0000, 1'b1, 32, 1'b0);
        waitForDone("maxXmax", 40);
        applyStimulus("onePointFiveX3", 32'h0001_8000, 32'h0000_0003,
                      64'h0000_0000_0004_8000, 32'h0000_0004, 1'b0, 2, 1'b0);
        waitForDone("onePointFiveX3", 40);
        applyStimulus("zeroA", 32'h0000_0000, 32'h1234_5678,
                      64'h0, 32'h0, 1'b0, 29, 1'b0);
        waitForDone("zeroA", 40);
        applyStimulus("zeroB", 32'hDEAD_BEEF, 32'h0000_0000,
                      64'h0, 32'h0, 1'b0, 1, 1'b0);
        waitForDone("zeroB", 40);
        applyStimulus("noOvfEdge", 32'h0001_0000, 32'hFFFF_0000,
                      64'h0000_FFFF_0000_0000, 32'hFFFF_0000, 1'b0, 32, 1'b0);
        waitForDone("noOvfEdge", 40);
        applyStimulus("ovfWrap", 32'h0002_0000, 32'h8000_0000,
                      64'h0001_0000_0000_0000, 32'h0000_0000, 1'b1, 32, 1'b0);
        waitForDone("ovfWrap", 40);

        $display("[TB] operand change and start during run");
        applyStimulus("ignoreDuringRun", 32'h0001_0000, 32'h8000_0000,
                      64'h0000_8000_0000_0000, 32'h8000_0000, 1'b0, 32, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        multiplicand = 32'hFFFF_FFFF;
        multiplier   = 32'hFFFF_FFFF;
        checkOutput("holdDuringRun product", product, 64'h0001_0000_0000_0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (25) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        checkOutput("busyAtE0p31", {63'd0, busy}, 64'd1);
        waitForDone("ignoreDuringRun", 5);
        @(negedge clk);
        checkOutput("noQueuedStart busy", {63'd0, busy}, 64'd0);

        $display("[TB] reset mid-run");
        applyStimulus("aborted", 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                      64'hFFFF_FFFE_0000_0001, 32'hFFFE_0000, 1'b1, 32, 1'b0);
        repeat (8) @(posedge clk);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        void'(scoreboard.pop_back());
        checkOutput("abort product", product, 64'd0);
        checkOutput("abort scaled", {32'd0, scaled}, 64'd0);
        checkOutput("abort ovf", {63'd0, ovf}, 64'd0);
        checkOutput("abort busy", {63'd0, busy}, 64'd0);
        checkOutput("abort done", {63'd0, done}, 64'd0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (40) @(negedge clk);
        checkOutput("afterAbort busy", {63'd0, busy}, 64'd0);
        applyStimulus("afterAbort", 32'h0001_8000, 32'h0000_0003,
                      64'h0000_0000_0004_8000, 32'h0000_0004, 1'b0, 2, 1'b0);
        waitForDone("afterAbort", 40);

        $display("[TB] back-to-back with start held high");
        applyStimulus("backToBack", 32'h0000_0002, 32'hFFFF_FFFF,
                      64'h0000_0001_FFFF_FFFE, 32'h0001_FFFF, 1'b0, 32, 1'b1);
        for (int k = 0; k < 2; k++) begin
            expect_t e;
            repeat (32) @(posedge clk);
            @(negedge clk);
            checkOutput("backToBack gap busy", {63'd0, busy}, 64'd0);
            @(posedge clk);
            #1;
            e.prod = 64'h0000_0001_FFFF_FFFE;
            e.scal = 32'h0001_FFFF;
            e.ovfl = 1'b0;
            e.lat  = 32;
            e.e0   = cycleCount;
            e.tag  = "backToBack";
            scoreboard.push_back(e);
            @(negedge clk);
            checkOutput("backToBack rerun busy", {63'd0, busy}, 64'd1);
        end
        start = 1'b0;
        waitForDone("backToBack", 40);

        repeat (40) @(negedge clk);
        checkOutput("scoreboardEmpty", 64'(scoreboard.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
